// File: rtl/saikoro_reader.sv
// Receive-side dice lamp decoder: captures a 7-lamp pattern, waits for it to hold steady,
// decodes it to a face 1..6 and keeps saturating per-face tallies.
module saikoro_reader #(
    parameter int unsigned STABLE = 3,
    parameter int unsigned TMO    = 63,
    parameter int unsigned CW     = 8
) (
    input  logic          ck,
    input  logic          reset,
    input  logic [6:0]    lamp,
    input  logic          sample,
    input  logic          clear,
    input  logic [2:0]    tally_sel,
    output logic [2:0]    value,
    output logic          valid,
    output logic          error,
    output logic          busy,
    output logic [CW-1:0] tally
);

    localparam logic [3:0] StableC = 4'(STABLE);
    localparam logic [7:0] TmoC    = 8'(TMO);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t        state;
    logic [6:0]    snap;
    logic [3:0]    run;
    logic [7:0]    age;
    logic [CW-1:0] tally_q [6];

    logic [2:0] lamp_face;
    logic [3:0] run_nx;
    logic [7:0] age_nx;
    logic       decode_go;
    logic       timeout_go;

    // Face of the pattern currently on the bus; 0 marks an illegal pattern.
    always_comb begin
        lamp_face = 3'd0;
        case (lamp)
            7'b0001000: lamp_face = 3'd1;
            7'b1000001: lamp_face = 3'd2;
            7'b0011100: lamp_face = 3'd3;
            7'b1010101: lamp_face = 3'd4;
            7'b1011101: lamp_face = 3'd5;
            7'b1110111: lamp_face = 3'd6;
            default:    lamp_face = 3'd0;
        endcase
    end

    // When a decode fires, the updated snap always equals lamp, so lamp is decoded directly.
    always_comb begin
        run_nx     = (lamp == snap) ? run + 4'd1 : 4'd1;
        age_nx     = age + 8'd1;
        decode_go  = 1'b0;
        timeout_go = 1'b0;
        if (state == StIdle) begin
            decode_go = sample && (StableC == 4'd1);
        end else begin
            decode_go  = (run_nx == StableC);
            timeout_go = !decode_go && (age_nx == TmoC);
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            snap  <= 7'd0;
            run   <= 4'd0;
            age   <= 8'd0;
            value <= 3'h0;
            valid <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            error <= 1'b0;

            if (decode_go) begin
                if (lamp_face != 3'd0) begin
                    value <= lamp_face;
                    valid <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end
            if (timeout_go) begin
                error <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (sample) begin
                        snap <= lamp;
                        run  <= 4'd1;
                        age  <= 8'd0;
                        if (StableC != 4'd1) begin
                            state <= StWait;
                            busy  <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    age  <= age_nx;
                    snap <= lamp;
                    run  <= run_nx;
                    if (decode_go || timeout_go) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase

            // Clear takes priority over a coincident increment.
            for (int i = 0; i < 6; i++) begin
                if (clear) begin
                    tally_q[i] <= '0;
                end else if (decode_go && (lamp_face == 3'(i + 1)) && (tally_q[i] != '1)) begin
                    tally_q[i] <= tally_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        tally = '0;
        case (tally_sel)
            3'd1:    tally = tally_q[0];
            3'd2:    tally = tally_q[1];
            3'd3:    tally = tally_q[2];
            3'd4:    tally = tally_q[3];
            3'd5:    tally = tally_q[4];
            3'd6:    tally = tally_q[5];
            default: tally = '0;
        endcase
    end

endmodule

// File: tb/tb_saikoro_reader.sv
// Directed bench for saikoro_reader: three instances cover STABLE=3, STABLE=1 and TMO=10/CW=2.
module tb_saikoro_reader;

    logic       ck = 1'b0;
    logic       reset;
    logic [6:0] lamp;
    logic       sample;
    logic       clear;
    logic [2:0] tally_sel;

    logic [2:0] a_value, b_value, c_value;
    logic       a_valid, b_valid, c_valid;
    logic       a_error, b_error, c_error;
    logic       a_busy, b_busy, c_busy;
    logic [7:0] a_tally, b_tally;
    logic [1:0] c_tally;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat [1:6];

    saikoro_reader #(.STABLE(3), .TMO(63), .CW(8)) u_a (
        .ck(ck), .reset(reset), .lamp(lamp), .sample(sample), .clear(clear),
        .tally_sel(tally_sel), .value(a_value), .valid(a_valid), .error(a_error),
        .busy(a_busy), .tally(a_tally)
    );

    saikoro_reader #(.STABLE(1), .TMO(63), .CW(8)) u_b (
        .ck(ck), .reset(reset), .lamp(lamp), .sample(sample), .clear(clear),
        .tally_sel(tally_sel), .value(b_value), .valid(b_valid), .error(b_error),
        .busy(b_busy), .tally(b_tally)
    );

    saikoro_reader #(.STABLE(3), .TMO(10), .CW(2)) u_c (
        .ck(ck), .reset(reset), .lamp(lamp), .sample(sample), .clear(clear),
        .tally_sel(tally_sel), .value(c_value), .valid(c_valid), .error(c_error),
        .busy(c_busy), .tally(c_tally)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        pat[1] = 7'b0001000;
        pat[2] = 7'b1000001;
        pat[3] = 7'b0011100;
        pat[4] = 7'b1010101;
        pat[5] = 7'b1011101;
        pat[6] = 7'b1110111;

        reset     = 1'b1;
        lamp      = 7'd0;
        sample    = 1'b0;
        clear     = 1'b0;
        tally_sel = 3'd0;
        step();
        step();
        reset = 1'b0;

        chk("rst_value", a_value, 3'd0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_error", a_error, 1'b0);
        chk("rst_busy", a_busy, 1'b0);

        // Full decode sweep, STABLE=3.
        for (int k = 1; k <= 6; k++) begin
            lamp   = pat[k];
            sample = 1'b1;
            step();
            sample = 1'b0;
            chk("sweep_busy_e0", a_busy, 1'b1);
            chk("sweep_valid_e0", a_valid, 1'b0);
            step();
            chk("sweep_valid_e1", a_valid, 1'b0);
            step();
            chk("sweep_valid_e2", a_valid, 1'b1);
            chk("sweep_value", a_value, 32'(k));
            chk("sweep_busy_e2", a_busy, 1'b0);
            tally_sel = 3'(k);
            #1;
            chk("sweep_tally", a_tally, 8'd1);
        end
        tally_sel = 3'd7;
        #1;
        chk("tally_sel7", a_tally, 8'd0);
        tally_sel = 3'd0;
        #1;
        chk("tally_sel0", a_tally, 8'd0);

        // Illegal patterns: error pulse, value and tallies untouched.
        lamp   = 7'b0000000;
        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        step();
        chk("ill0_error", a_error, 1'b1);
        chk("ill0_valid", a_valid, 1'b0);
        chk("ill0_value", a_value, 3'd6);
        tally_sel = 3'd6;
        #1;
        chk("ill0_tally6", a_tally, 8'd1);
        step();
        chk("ill0_error_drop", a_error, 1'b0);

        lamp   = 7'b1111111;
        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        step();
        chk("ill7f_error", a_error, 1'b1);
        chk("ill7f_valid", a_valid, 1'b0);
        chk("ill7f_value", a_value, 3'd6);
        chk("ill7f_tally6", a_tally, 8'd1);

        // Reset mid-WAIT acts without a clock edge.
        lamp   = pat[5];
        sample = 1'b1;
        step();
        sample = 1'b0;
        chk("midwait_busy", a_busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_value", a_value, 3'd0);
        chk("async_rst_busy", a_busy, 1'b0);
        chk("async_rst_valid", a_valid, 1'b0);
        chk("async_rst_error", a_error, 1'b0);
        chk("async_rst_tally6", a_tally, 8'd0);
        step();
        reset = 1'b0;

        lamp   = pat[2];
        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        chk("fresh_valid_e1", a_valid, 1'b0);
        step();
        chk("fresh_valid_e2", a_valid, 1'b1);
        chk("fresh_value", a_value, 3'd2);

        // STABLE=1: sample held high gives a decode every clock.
        pulse_reset();
        lamp   = pat[6];
        sample = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("s1_valid", b_valid, 1'b1);
            chk("s1_value", b_value, 3'd6);
            chk("s1_busy", b_busy, 1'b0);
        end
        sample = 1'b0;
        step();
        chk("s1_valid_drop", b_valid, 1'b0);
        tally_sel = 3'd6;
        #1;
        chk("s1_tally6", b_tally, 8'd4);

        // Glitch restart: pattern changes at E1, decode lands at E3.
        pulse_reset();
        lamp   = pat[5];
        sample = 1'b1;
        step();
        sample = 1'b0;
        lamp   = pat[4];
        step();
        chk("glitch_valid_e1", a_valid, 1'b0);
        step();
        chk("glitch_valid_e2", a_valid, 1'b0);
        chk("glitch_busy_e2", a_busy, 1'b1);
        step();
        chk("glitch_valid_e3", a_valid, 1'b1);
        chk("glitch_value", a_value, 3'd4);
        tally_sel = 3'd5;
        #1;
        chk("glitch_tally5", a_tally, 8'd0);
        tally_sel = 3'd4;
        #1;
        chk("glitch_tally4", a_tally, 8'd1);

        // Timeout with TMO=10: lamp toggles every clock.
        pulse_reset();
        lamp   = pat[1];
        sample = 1'b1;
        step();
        sample = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            lamp = (k % 2 == 1) ? pat[2] : pat[1];
            step();
            chk("tmo_error_early", c_error, 1'b0);
            chk("tmo_busy_early", c_busy, 1'b1);
        end
        lamp = pat[1];
        step();
        chk("tmo_error", c_error, 1'b1);
        chk("tmo_busy", c_busy, 1'b0);
        chk("tmo_valid", c_valid, 1'b0);
        step();
        chk("tmo_error_drop", c_error, 1'b0);

        // Saturation with CW=2.
        lamp      = pat[3];
        tally_sel = 3'd3;
        for (int n = 0; n < 5; n++) begin
            sample = 1'b1;
            step();
            sample = 1'b0;
            step();
            step();
            chk("sat_valid", c_valid, 1'b1);
        end
        chk("sat_tally3", c_tally, 2'd3);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_tally3", c_tally, 2'd0);

        // Clear on the same edge as a decode wins.
        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_dec_valid", c_valid, 1'b1);
        chk("clr_dec_tally3", c_tally, 2'd0);

        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        step();
        chk("post_clr_tally3", c_tally, 2'd1);

        // sample during WAIT is ignored.
        sample = 1'b1;
        step();
        step();
        sample = 1'b0;
        step();
        chk("wait_sample_valid", c_valid, 1'b1);
        step();
        chk("wait_sample_valid_e3", c_valid, 1'b0);
        chk("wait_sample_busy_e3", c_busy, 1'b0);
        step();
        step();
        chk("wait_sample_valid_e5", c_valid, 1'b0);
        chk("wait_sample_tally3", c_tally, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saikoro_reader.md
# saikoro_reader

Receive-side decoder for the seven-lamp dice display. It samples a 7-bit lamp pattern on request and requires the pattern to hold steady for a programmable number of clocks. It then decodes the pattern back to a face value 1..6, or flags it as illegal, and keeps a saturating per-face tally. It sits at the far end of the lamp bus from the dice counter/decoder, for self-check and statistics.

## Interface
- STABLE, 3: consecutive clocks the lamp pattern must be identical before decoding; legal range 1..15.
- TMO, 63: maximum clocks spent in WAIT before giving up; legal range STABLE..255.
- CW, 8: width of each per-face tally counter.

- ck  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- lamp  in  7  lamp pattern, bit 6..0, 1 = lamp lit.
- sample  in  1  request to read the dice; only seen in IDLE.
- clear  in  1  synchronous clear of all tallies.
- tally_sel  in  3  face whose tally is shown on tally (1..6; 0 and 7 read 0).
- value  out  3  last successfully decoded face, held until the next good decode.
- valid  out  1  one-cycle pulse: value was just updated.
- error  out  1  one-cycle pulse: illegal pattern, or timeout.
- busy  out  1  high while in WAIT.
- tally  out  CW  count for tally_sel, combinational from the registers.

## Operation
- Legal patterns:
  - 7'b0001000 → 1
  - 7'b1000001 → 2
  - 7'b0011100 → 3
  - 7'b1010101 → 4
  - 7'b1011101 → 5
  - 7'b1110111 → 6
  - Every other pattern, including all-zero, is illegal.
- FSM states: IDLE, WAIT.
- Internal registers:
  - snap[6:0]: captured pattern.
  - run[3:0]: stable-clock count.
  - age[7:0]: clocks spent in WAIT.
- IDLE, sample=1:
  - snap←lamp, run←1, age←0.
  - If STABLE=1: decode immediately and stay in IDLE.
  - Otherwise go to WAIT.
- IDLE, sample=0: nothing changes.
- WAIT, each edge:
  - age←age+1.
  - If lamp==snap: run←run+1.
  - Else: snap←lamp, run←1 (restart stability count).
- WAIT exit on stability: when the updated run equals STABLE, decode snap and go to IDLE.
- WAIT exit on timeout: when the updated age equals TMO and stability is not reached on that edge, pulse error and go to IDLE. Stability on the same edge takes priority over timeout.
- Decode, legal pattern: value←face, valid←1 for one cycle, tally[face]←tally[face]+1, saturating at 2^CW−1.
- Decode, illegal pattern: error←1 for one cycle; value and tallies unchanged.
- sample while in WAIT is ignored; no queuing.
- clear=1: all six tallies←0 on that edge. If clear coincides with an increment, clear wins.
- reset, at any time including mid-WAIT:
  - state←IDLE, snap←0, run←0, age←0.
  - value←3'h0, valid←0, error←0, busy←0, all tallies←0.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- valid, error and busy are registered. value changes on the same edge that raises valid.
- Stable input, sample high at edge E0: valid is high in the cycle after edge E0+STABLE−1.
  - STABLE=3 → valid after E2.
  - STABLE=1 → valid after E0.
- busy rises after E0 and falls on the decode or timeout edge. The earliest next accepted sample is the edge after valid/error rises.
- If the pattern changes on edge Ek, the count restarts there. Decode then happens no earlier than Ek+STABLE−1.
- Timeout error is high in the cycle after edge E0+TMO.
- tally reflects an increment in the cycle after the decode edge.
- Back-to-back: sample held high continuously gives one decode every STABLE clocks (STABLE>1), or every clock (STABLE=1).

## Test plan
- Reset: reset pulse mid-WAIT → value=0, valid=0, error=0, busy=0, all tallies 0 immediately. sample after reset release starts a fresh capture.
- Full decode sweep: for each of the six legal patterns, hold the lamp, pulse sample, STABLE=3 → valid exactly 2 edges after the sample edge, value = 1..6 respectively, tally_sel=k reads 1 for each face.
- Illegal pattern and STABLE=1 with back-to-back samples:
  - Hold 7'b0000000, pulse sample → error pulse, no valid, value keeps its previous face, tallies unchanged.
  - Repeat with 7'b1111111.
  - STABLE=1, hold 7'b1110111, sample high for 4 clocks → 4 valid pulses on consecutive cycles, value=6, tally[6]=4.
- Glitch restart: lamp 7'b1011101, sample at E0, lamp toggles to 7'b1010101 at E1 and stays → valid after E1+2 with value=4; tally[5] unchanged.
- Timeout: TMO=10, lamp toggles every clock → error after E0+10, busy low after it, no valid.
- Saturation and clear:
  - CW=2: 5 decodes of face 3 → tally=3.
  - Assert clear on the same edge as a face-3 decode → tally=0.
  - sample asserted during WAIT causes no extra decode.
